// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage encodings and address map defaults
package cpu_pkg;

    typedef enum logic [2:0] {
        PC_PLUS4  = 3'd0,
        PC_BRANCH = 3'd1,
        PC_JUMP   = 3'd2,
        PC_JR     = 3'd3
    } next_pc_op_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;
    localparam logic [31:0] DEF_IMEM_LO   = 32'h0000_3000;
    localparam logic [31:0] DEF_IMEM_HI   = 32'h0000_6ffc;

endpackage

// File: rtl/pc_src_mux.sv
// rtl/pc_src_mux.sv - NUM_SRC:1 next-PC selector with pc+4 fallback
module pc_src_mux #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 8,
    parameter int SEL_W   = 3
) (
    input  logic [WIDTH-1:0]         pc,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_SRC*WIDTH-1:0] src_flat,
    output logic [WIDTH-1:0]         next_pc
);

    // Unpopulated selector codes fall back to sequential fetch.
    always_comb begin
        next_pc = pc + WIDTH'(4);
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                next_pc = src_flat[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC register with stall, buffered redirects and exceptions
module pc_gen
    import cpu_pkg::*;
#(
    parameter int              WIDTH     = 32,
    parameter int              NUM_SRC   = 8,
    parameter int              SEL_W     = 3,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
    parameter logic [WIDTH-1:0] IMEM_LO   = WIDTH'(DEF_IMEM_LO),
    parameter logic [WIDTH-1:0] IMEM_HI   = WIDTH'(DEF_IMEM_HI)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic [SEL_W-1:0]         next_pc_op,
    input  logic [NUM_SRC*WIDTH-1:0] src_flat,
    input  logic                     redirect_valid,
    input  logic [WIDTH-1:0]         redirect_pc,
    input  logic                     exc_req,
    input  logic                     eret_req,
    input  logic [WIDTH-1:0]         epc_in,
    output logic [WIDTH-1:0]         pc_out,
    output logic                     pend_valid,
    output logic                     redirected,
    output logic                     adel
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic             pend_valid_q, pend_valid_d;
    logic             redirected_q, redirected_d;
    logic [WIDTH-1:0] mux_pc;

    pc_src_mux #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_src_mux (
        .pc       (pc_q),
        .sel      (next_pc_op),
        .src_flat (src_flat),
        .next_pc  (mux_pc)
    );

    always_comb begin
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        redirected_d = 1'b0;
        if (exc_req) begin
            pc_d         = EXC_VEC;
            pend_valid_d = 1'b0;
            redirected_d = 1'b1;
        end else if (eret_req) begin
            pc_d         = epc_in;
            pend_valid_d = 1'b0;
            redirected_d = 1'b1;
        end else if (stall) begin
            // Keep only the youngest redirect seen while the front end is frozen.
            if (redirect_valid) begin
                pend_valid_d = 1'b1;
                pend_pc_d    = redirect_pc;
            end
        end else if (redirect_valid) begin
            pc_d         = redirect_pc;
            pend_valid_d = 1'b0;
            redirected_d = 1'b1;
        end else if (pend_valid_q) begin
            pc_d         = pend_pc_q;
            pend_valid_d = 1'b0;
            redirected_d = 1'b1;
        end else begin
            pc_d = mux_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_VEC;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
            redirected_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            redirected_q <= redirected_d;
        end
    end

    assign pc_out     = pc_q;
    assign pend_valid = pend_valid_q;
    assign redirected = redirected_q;
    assign adel       = (pc_q[1:0] != 2'b00) | (pc_q < IMEM_LO) | (pc_q > IMEM_HI);

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
module tb_pc_gen;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid, exc_req, eret_req;
    logic [2:0]  next_pc_op;
    logic [31:0] src [8];
    logic [255:0] src_flat;
    logic [31:0] redirect_pc, epc_in, pc_out;
    logic        pend_valid, redirected, adel;

    logic        r16;
    logic [2:0]  op16;
    logic [15:0] src16 [4];
    logic [63:0] src16_flat;
    logic [15:0] pc16;
    logic        pend16, red16, adel16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 8; i++) src_flat[i*32 +: 32] = src[i];
        for (int i = 0; i < 4; i++) src16_flat[i*16 +: 16] = src16[i];
    end

    pc_gen dut (
        .clk(clk), .reset(reset), .stall(stall), .next_pc_op(next_pc_op),
        .src_flat(src_flat), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .exc_req(exc_req), .eret_req(eret_req), .epc_in(epc_in),
        .pc_out(pc_out), .pend_valid(pend_valid), .redirected(redirected), .adel(adel)
    );

    pc_gen #(
        .WIDTH(16), .NUM_SRC(4), .SEL_W(3),
        .RESET_VEC(16'hfff8), .EXC_VEC(16'h0100),
        .IMEM_LO(16'h0000), .IMEM_HI(16'hfffc)
    ) dut16 (
        .clk(clk), .reset(r16), .stall(1'b0), .next_pc_op(op16),
        .src_flat(src16_flat), .redirect_valid(1'b0), .redirect_pc(16'h0),
        .exc_req(1'b0), .eret_req(1'b0), .epc_in(16'h0),
        .pc_out(pc16), .pend_valid(pend16), .redirected(red16), .adel(adel16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc, input logic pv,
                             input logic rd, input logic ad);
        chk({tag, ".pc"}, pc_out, pc);
        chk({tag, ".pend"}, {31'b0, pend_valid}, {31'b0, pv});
        chk({tag, ".red"}, {31'b0, redirected}, {31'b0, rd});
        chk({tag, ".adel"}, {31'b0, adel}, {31'b0, ad});
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; exc_req = 1'b0; eret_req = 1'b0;
        next_pc_op = PC_PLUS4; redirect_pc = '0; epc_in = '0;
        for (int i = 0; i < 8; i++) src[i] = 32'h0;
        r16 = 1'b1; op16 = 3'd7;
        for (int i = 0; i < 4; i++) src16[i] = 16'h0;

        step();
        chk_state("reset", 32'h3000, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        src[0] = 32'h3004; step(); chk_state("seq1", 32'h3004, 1'b0, 1'b0, 1'b0);
        src[0] = 32'h3008; step(); chk_state("seq2", 32'h3008, 1'b0, 1'b0, 1'b0);
        src[0] = 32'h300c; step(); chk_state("seq3", 32'h300c, 1'b0, 1'b0, 1'b0);

        // Stalled redirect is buffered and released on the first free edge.
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h3400; src[0] = 32'h3010;
        step(); chk_state("stall1", 32'h300c, 1'b1, 1'b0, 1'b0);
        redirect_valid = 1'b0;
        step(); chk_state("stall2", 32'h300c, 1'b1, 1'b0, 1'b0);
        stall = 1'b0;
        step(); chk_state("release", 32'h3400, 1'b0, 1'b1, 1'b0);
        src[0] = 32'h3404;
        step(); chk_state("after_rel", 32'h3404, 1'b0, 1'b0, 1'b0);

        // Newer pending redirect overwrites older one.
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h3500; step();
        redirect_pc = 32'h3600; step();
        stall = 1'b0; redirect_valid = 1'b0;
        step(); chk_state("overwrite", 32'h3600, 1'b0, 1'b1, 1'b0);

        // Live redirect beats the pending one; the pending one is dropped.
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h3700; step();
        stall = 1'b0; redirect_pc = 32'h3800;
        step(); chk_state("live_wins", 32'h3800, 1'b0, 1'b1, 1'b0);
        redirect_valid = 1'b0; src[0] = 32'h3804;
        step(); chk_state("pend_dropped", 32'h3804, 1'b0, 1'b0, 1'b0);

        // Exception under stall with pending redirect, then eret.
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h3900;
        step(); chk_state("pend_exc", 32'h3804, 1'b1, 1'b0, 1'b0);
        redirect_valid = 1'b0; exc_req = 1'b1;
        step(); chk_state("exc", 32'h4180, 1'b0, 1'b1, 1'b0);
        exc_req = 1'b0; eret_req = 1'b1; epc_in = 32'h3010; stall = 1'b0;
        step(); chk_state("eret", 32'h3010, 1'b0, 1'b1, 1'b0);
        eret_req = 1'b0; stall = 1'b1;
        step(); chk_state("hold_post_eret", 32'h3010, 1'b0, 1'b0, 1'b0);

        exc_req = 1'b1; eret_req = 1'b1; epc_in = 32'h3020;
        step(); chk_state("exc_over_eret", 32'h4180, 1'b0, 1'b1, 1'b0);
        exc_req = 1'b0; eret_req = 1'b0; stall = 1'b0;

        // Source selection and address-error boundaries.
        next_pc_op = PC_JUMP; src[2] = 32'h3002;
        step(); chk_state("misalign", 32'h3002, 1'b0, 1'b0, 1'b1);
        src[2] = 32'h7000;
        step(); chk_state("above_hi", 32'h7000, 1'b0, 1'b0, 1'b1);
        src[2] = 32'h6ffc;
        step(); chk_state("at_hi", 32'h6ffc, 1'b0, 1'b0, 1'b0);
        src[2] = 32'h2ffc;
        step(); chk_state("below_lo", 32'h2ffc, 1'b0, 1'b0, 1'b1);
        next_pc_op = PC_JR; src[3] = 32'h5000;
        step(); chk_state("jr", 32'h5000, 1'b0, 1'b0, 1'b0);
        next_pc_op = 3'd7; src[7] = 32'h6000;
        step(); chk_state("src7", 32'h6000, 1'b0, 1'b0, 1'b0);

        // Reset discards a pending redirect even with a live one present.
        next_pc_op = PC_PLUS4; src[0] = 32'h6004;
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h3a00;
        step(); chk_state("pre_reset", 32'h6000, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        step(); chk_state("mid_reset", 32'h3000, 1'b0, 1'b0, 1'b0);
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; src[0] = 32'h3004;
        step(); chk_state("post_reset", 32'h3004, 1'b0, 1'b0, 1'b0);

        // Narrow instance: out-of-range selector increments and wraps.
        step();
        chk("w16.reset", {16'h0, pc16}, 32'h0000_fff8);
        r16 = 1'b0;
        step(); chk("w16.inc", {16'h0, pc16}, 32'h0000_fffc);
        chk("w16.adel_hi", {31'b0, adel16}, 32'h0);
        step(); chk("w16.wrap", {16'h0, pc16}, 32'h0000_0000);
        op16 = 3'd1; src16[1] = 16'h0123;
        step(); chk("w16.sel", {16'h0, pc16}, 32'h0000_0123);
        chk("w16.adel_mis", {31'b0, adel16}, 32'h1);
        chk("w16.red", {31'b0, red16}, 32'h0);
        chk("w16.pend", {31'b0, pend16}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
